// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and types
// for the parametrised FWFT FIFO.
package fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_param_ctrl.sv
// fifo_param_ctrl: pointers, occupancy,
// registered flags and error pulses.
module fifo_param_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int PW = clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  output logic          wr_en,
  output logic [PW-1:0] wr_addr,
  output logic [PW-1:0] rd_addr,
  output logic [CW-1:0] count,
  output fifo_status_t  status,
  output logic          overflow,
  output logic          underflow
);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;
  logic [CW-1:0] cnt_nxt;

  // Accept rules; a pop frees a slot
  // so a full FIFO still takes a push.
  always_comb begin
    push_ok = push & (~status.full | pop);
    pop_ok  = pop & ~status.empty;
    cnt_nxt = count
            + CW'(push_ok)
            - CW'(pop_ok);
  end

  assign wr_en   = push_ok & rst_n;
  assign wr_addr = wr_ptr;
  assign rd_addr = rd_ptr;

  // State update; flags come from the
  // next count so they track count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      status    <= '{full: 1'b0,
                     empty: 1'b1,
                     almost_full: 1'b0,
                     almost_empty: 1'b1};
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + PW'(1);
      count <= cnt_nxt;
      status.full <=
        (cnt_nxt == CW'(DEPTH));
      status.empty <=
        (cnt_nxt == '0);
      status.almost_full <=
        (cnt_nxt >= CW'(AF_LEVEL));
      status.almost_empty <=
        (cnt_nxt <= CW'(AE_LEVEL));
      overflow <=
        push & status.full & ~pop;
      underflow <=
        pop & status.empty;
    end
  end

endmodule

// File: rtl/fifo_param.sv
// fifo_param: DEPTH x WIDTH storage with
// first-word-fall-through head.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  data_in_valid,
  input  logic                  pop_fifo,
  output logic [WIDTH-1:0]      data_out,
  output logic                  data_out_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic [PW-1:0]    wr_addr;
  logic [PW-1:0]    rd_addr;
  fifo_status_t     status;

  fifo_param_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (data_in_valid),
    .pop       (pop_fifo),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .count     (count),
    .status    (status),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Storage write; contents are never
  // reset, the head just reads mem.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= data_in;
  end

  assign data_out       = mem[rd_addr];
  assign data_out_valid = ~status.empty;
  assign fifo_full      = status.full;
  assign fifo_empty     = status.empty;
  assign almost_full    = status.almost_full;
  assign almost_empty   = status.almost_empty;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: vector table plus
// scoreboard for fifo_param.
module tb_fifo_param;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data_in;
  logic             data_in_valid;
  logic             pop_fifo;
  logic [WIDTH-1:0] data_out;
  logic             data_out_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic             almost_full;
  logic             almost_empty;
  logic [2:0]       count;
  logic             overflow;
  logic             underflow;

  fifo_param #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .pop_fifo       (pop_fifo),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .count          (count),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p;
    logic [63:0] d;
    logic        q;
    int          cnt;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t        tv[$];
  logic [63:0] sb[$];
  int          mcount;
  int          tests;
  int          fails;
  int          vi;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0d: got %0h want %0h",
               nm, vi, act, exp);
    end
  endtask

  task automatic add(input logic p,
                     input logic [63:0] d,
                     input logic q,
                     input int c,
                     input logic f,
                     input logic e,
                     input logic af,
                     input logic ae,
                     input logic ov,
                     input logic ud);
    vec_t v;
    v = '{p, d, q, c, f, e, af, ae, ov, ud};
    tv.push_back(v);
  endtask

  // One clock of stimulus; the model
  // decides acceptance and data order.
  task automatic step(input logic p,
                      input logic [63:0] d,
                      input logic q);
    logic pok;
    logic qok;
    pok = p && (mcount < DEPTH || q);
    qok = q && (mcount != 0);
    if (qok)
      chk("head_pop", data_out, sb[0]);
    data_in_valid = p;
    data_in       = d;
    pop_fifo      = q;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    pop_fifo      = 1'b0;
    if (qok)
      sb.delete(0);
    if (pok)
      sb.push_back(d);
    mcount = mcount + int'(pok) - int'(qok);
    chk("count_model", count, mcount);
    chk("valid", data_out_valid, mcount != 0);
    if (mcount != 0)
      chk("head_now", data_out, sb[0]);
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    vi            = -1;
    mcount        = 0;
    rst_n         = 1'b0;
    data_in       = '0;
    data_in_valid = 1'b0;
    pop_fifo      = 1'b0;

    //  p  d       q  c  f  e  af ae ov ud
    add(0, 64'h0,  0, 0, 0, 1, 0, 1, 0, 0);
    add(1, 64'hA0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 64'hA1, 0, 2, 0, 0, 0, 0, 0, 0);
    add(1, 64'hA2, 0, 3, 0, 0, 1, 0, 0, 0);
    add(1, 64'hA3, 0, 4, 1, 0, 1, 0, 0, 0);
    add(1, 64'hA4, 0, 4, 1, 0, 1, 0, 1, 0);
    add(0, 64'h0,  0, 4, 1, 0, 1, 0, 0, 0);
    add(0, 64'h0,  1, 3, 0, 0, 1, 0, 0, 0);
    add(0, 64'h0,  1, 2, 0, 0, 0, 0, 0, 0);
    add(0, 64'h0,  1, 1, 0, 0, 0, 1, 0, 0);
    add(0, 64'h0,  1, 0, 0, 1, 0, 1, 0, 0);
    add(1, 64'h10, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 64'h11, 0, 2, 0, 0, 0, 0, 0, 0);
    add(1, 64'h12, 0, 3, 0, 0, 1, 0, 0, 0);
    add(1, 64'h13, 0, 4, 1, 0, 1, 0, 0, 0);
    add(1, 64'hB0, 1, 4, 1, 0, 1, 0, 0, 0);
    add(0, 64'h0,  1, 3, 0, 0, 1, 0, 0, 0);
    add(0, 64'h0,  1, 2, 0, 0, 0, 0, 0, 0);
    add(0, 64'h0,  1, 1, 0, 0, 0, 1, 0, 0);
    add(0, 64'h0,  1, 0, 0, 1, 0, 1, 0, 0);
    add(1, 64'hC0, 1, 1, 0, 0, 0, 1, 0, 1);
    add(0, 64'h0,  1, 0, 0, 1, 0, 1, 0, 0);
    add(0, 64'h0,  1, 0, 0, 1, 0, 1, 0, 1);
    add(0, 64'h0,  0, 0, 0, 1, 0, 1, 0, 0);

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      vi = i;
      step(tv[i].p, tv[i].d, tv[i].q);
      chk("cnt", count, tv[i].cnt);
      chk("full", fifo_full, tv[i].full);
      chk("empty", fifo_empty, tv[i].empty);
      chk("af", almost_full, tv[i].af);
      chk("ae", almost_empty, tv[i].ae);
      chk("ovf", overflow, tv[i].ovf);
      chk("udf", underflow, tv[i].udf);
    end

    // Wrap-around: pointers lap the
    // array several times at count 1.
    vi = 100;
    step(1, 64'hE0, 0);
    for (int k = 1; k <= 10; k++) begin
      vi = 100 + k;
      step(1, 64'hE0 + 64'(k), 1);
      chk("cnt_le2", count <= 3'd2, 1);
    end
    vi = 111;
    step(0, 64'h0, 1);
    chk("wrap_empty", fifo_empty, 1);

    // Reset mid-stream clears at once
    // and blocks pushes while held.
    vi = 200;
    step(1, 64'h70, 0);
    step(1, 64'h71, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", fifo_empty, 1);
    chk("arst_valid", data_out_valid, 0);
    data_in_valid = 1'b1;
    data_in       = 64'h99;
    @(posedge clk);
    #1;
    chk("rst_push_cnt", count, 0);
    data_in_valid = 1'b0;
    rst_n         = 1'b1;
    sb.delete();
    mcount = 0;
    vi = 201;
    step(1, 64'h55, 0);
    chk("post_rst_data", data_out, 64'h55);
    vi = 202;
    step(0, 64'h0, 1);
    chk("post_rst_empty", fifo_empty, 1);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO replacing the fixed 4-entry × 64-bit register FIFO. It integrates the storage array with its pointer/count control and adds occupancy count, almost-full/empty thresholds and error pulses. It sits between a producer using a valid-only push and a consumer that pops from a first-word-fall-through (FWFT) head. It is one clock domain and has no backpressure beyond the flags.

## Interface
- WIDTH, 64: data word width in bits, ≥1.
- DEPTH, 4: number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL; 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL; 0..DEPTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  write data.
- data_in_valid  in  1  push request.
- pop_fifo  in  1  pop request; consumes the current head.
- data_out  out  WIDTH  head word (FWFT).
- data_out_valid  out  1  head word is valid; equals !fifo_empty.
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  one-cycle pulse: push dropped.
- underflow  out  1  one-cycle pulse: pop ignored.

## Operation
- Storage is DEPTH × WIDTH. write_ptr and read_ptr are each $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- push_ok = data_in_valid & (!fifo_full | pop_fifo). On push_ok, mem[write_ptr] ← data_in and write_ptr advances by 1.
- pop_ok = pop_fifo & !fifo_empty. On pop_ok, read_ptr advances by 1.
- count next value = count + push_ok − pop_ok.
- Full with simultaneous push and pop: both are accepted and count is unchanged.
- Empty with simultaneous push and pop: the push is accepted, the pop is ignored and underflow pulses. Data never bypasses storage.
- Push while full without a pop: data is dropped, pointers and memory are unchanged, overflow pulses.
- Pop while empty: no state change, underflow pulses.
- data_out = mem[read_ptr], a combinational read. The value is don't-care while fifo_empty, but implementations must hold the last array contents (no X injection).
- Status flags are registered, computed from the next count, so they are valid in the same cycle as count.
- Reset values: pointers 0, count 0, fifo_empty 1, data_out_valid 0, fifo_full 0, almost_empty 1 (AE_LEVEL ≥ 0), almost_full 0, overflow 0, underflow 0.
- Memory contents are not reset. data_out after reset reads mem[0] and is undefined.

## Timing
- Write-to-read latency is 1 cycle. A word pushed at edge N is visible on data_out, with data_out_valid=1, after edge N if the FIFO was empty.
- Pop takes effect at the edge. The next head appears combinationally after that edge.
- Flags, count and error pulses update on the same edge as the operation that caused them. overflow and underflow are high for exactly one cycle per offending request.
- Reset asserted mid-operation: all control state clears immediately (asynchronously), in-flight data is lost, and pushes are ignored while rst_n=0.
- The first push is accepted on the first rising edge after rst_n deasserts.

## Structure
- Package fifo_pkg holds a function for the pointer width (clog2) and the shared status struct typedef {full, empty, almost_full, almost_empty}.
- Sub-module fifo_param_ctrl contains the pointers, count, flags and error pulses, and outputs the write enable and write/read addresses.
- The storage array with its combinational read lives in the top module.

## Test plan
- Reset, then idle: count=0, fifo_empty=1, almost_empty=1, fifo_full=0, no error pulses.
- DEPTH=4: push 0xA0..0xA3 on consecutive cycles. Result: fifo_full=1, count=4, almost_full=1 at AF_LEVEL=3 after the 3rd push.
- Continue from full: 5th push 0xA4 → overflow pulses 1 cycle, count stays 4. Then pop 4 times → data_out reads 0xA0, 0xA1, 0xA2, 0xA3 and fifo_empty=1.
- Full with push 0xB0 and pop in the same cycle: count stays 4, head advances to the next word, and 0xB0 emerges after three more pops.
- Empty with simultaneous push 0xC0 and pop: underflow pulses, count=1, data_out=0xC0. Then pop while empty → underflow pulses, pointers unchanged.
- Wrap-around: 10 interleaved push/pop pairs with incrementing data. Output order matches input order, and count never exceeds 2. Assert rst_n=0 mid-stream → count=0 immediately, then a new push reads back correctly.
